// File: rtl/mem_port_arbiter.sv
// Three-way arbiter (AXI-Lite host, CPU data, CPU fetch) for one single-port,
// synchronous-read memory. Host wins bounded bursts; D and I alternate.
module mem_port_arbiter #(
    parameter int ADDR_W         = 10,
    parameter int HOST_MAX_BURST = 4
) (
    input  logic              S_AXI_ACLK,
    input  logic              S_AXI_ARESETN,

    input  logic              h_req_i,
    input  logic              h_we_i,
    input  logic [31:0]       h_addr_i,
    input  logic [31:0]       h_wdata_i,
    input  logic [3:0]        h_wstrb_i,
    output logic              h_gnt_o,
    output logic              h_rvalid_o,

    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [31:0]       d_addr_i,
    input  logic [31:0]       d_wdata_i,
    input  logic [3:0]        d_wstrb_i,
    output logic              d_gnt_o,
    output logic              d_rvalid_o,

    input  logic              i_req_i,
    input  logic [31:0]       i_addr_i,
    output logic              i_gnt_o,
    output logic              i_rvalid_o,

    output logic [31:0]       rdata_o,

    output logic              mem_en_o,
    output logic [3:0]        mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    input  logic [31:0]       mem_rdata_i
);

    typedef enum logic [1:0] {
        OWN_H = 2'd0,
        OWN_D = 2'd1,
        OWN_I = 2'd2
    } owner_e;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] waddr;
        logic [31:0]       wdata;
        logic [3:0]        wstrb;
    } mreq_t;

    localparam logic [3:0] BURST_LIM = 4'(HOST_MAX_BURST);

    mreq_t  h_r, d_r, i_r, sel_r;
    logic   rr_ptr;
    logic   [3:0] burst_cnt;
    logic   rd_vld;
    owner_e rd_own;
    logic   cpu_req, h_win, cpu_gnt, any_gnt;
    logic   gnt_h, gnt_d, gnt_i;

    // Byte offset and aliased upper address bits are deliberately dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{h_addr_i[31:ADDR_W+2], h_addr_i[1:0],
                                d_addr_i[31:ADDR_W+2], d_addr_i[1:0],
                                i_addr_i[31:ADDR_W+2], i_addr_i[1:0]};

    assign h_r = '{we: h_we_i, waddr: h_addr_i[ADDR_W+1:2], wdata: h_wdata_i, wstrb: h_wstrb_i};
    assign d_r = '{we: d_we_i, waddr: d_addr_i[ADDR_W+1:2], wdata: d_wdata_i, wstrb: d_wstrb_i};
    assign i_r = '{we: 1'b0,   waddr: i_addr_i[ADDR_W+1:2], wdata: 32'h0,     wstrb: 4'h0};

    assign cpu_req = d_req_i | i_req_i;
    assign h_win   = h_req_i && ((burst_cnt < BURST_LIM) || !cpu_req);

    always_comb begin
        gnt_h = 1'b0;
        gnt_d = 1'b0;
        gnt_i = 1'b0;
        if (S_AXI_ARESETN) begin
            if (h_win) begin
                gnt_h = 1'b1;
            end else if (d_req_i && i_req_i) begin
                gnt_d = ~rr_ptr;
                gnt_i = rr_ptr;
            end else begin
                gnt_d = d_req_i;
                gnt_i = i_req_i;
            end
        end
    end

    assign cpu_gnt = gnt_d | gnt_i;
    assign any_gnt = gnt_h | cpu_gnt;

    always_comb begin
        sel_r = i_r;
        if (gnt_h)      sel_r = h_r;
        else if (gnt_d) sel_r = d_r;
    end

    assign h_gnt_o     = gnt_h;
    assign d_gnt_o     = gnt_d;
    assign i_gnt_o     = gnt_i;
    assign mem_en_o    = any_gnt;
    assign mem_we_o    = (any_gnt && sel_r.we) ? sel_r.wstrb : 4'b0000;
    assign mem_addr_o  = sel_r.waddr;
    assign mem_wdata_o = sel_r.wdata;

    // An idle CPU side resets the host burst budget, even on a host grant.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            rr_ptr    <= 1'b0;
            burst_cnt <= 4'd0;
        end else begin
            if (cpu_gnt)
                rr_ptr <= gnt_d;
            if (cpu_gnt || !cpu_req)
                burst_cnt <= 4'd0;
            else if (gnt_h && burst_cnt != 4'hF)
                burst_cnt <= burst_cnt + 4'd1;
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            rd_vld <= 1'b0;
            rd_own <= OWN_H;
        end else begin
            rd_vld <= any_gnt && !sel_r.we;
            if (gnt_h)      rd_own <= OWN_H;
            else if (gnt_d) rd_own <= OWN_D;
            else if (gnt_i) rd_own <= OWN_I;
        end
    end

    assign h_rvalid_o = rd_vld && (rd_own == OWN_H);
    assign d_rvalid_o = rd_vld && (rd_own == OWN_D);
    assign i_rvalid_o = rd_vld && (rd_own == OWN_I);
    assign rdata_o    = mem_rdata_i;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: behavioural arbitration/memory model checked every
// negedge, plus directed literal expectations for each scenario.
module tb_mem_port_arbiter;
    localparam int AW  = 10;
    localparam int HMB = 4;

    logic clk = 1'b0, rst_n = 1'b0;
    logic h_req = 0, h_we = 0, d_req = 0, d_we = 0, i_req = 0;
    logic [31:0] h_addr = 0, h_wdata = 0, d_addr = 0, d_wdata = 0, i_addr = 0;
    logic [3:0]  h_wstrb = 0, d_wstrb = 0;
    logic h_gnt, h_rv, d_gnt, d_rv, i_gnt, i_rv, mem_en;
    logic [31:0] rdata, mem_wdata, mem_rdata;
    logic [3:0]  mem_we;
    logic [AW-1:0] mem_addr;

    int total = 0, bad = 0;

    mem_port_arbiter #(.ADDR_W(AW), .HOST_MAX_BURST(HMB)) dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
        .h_req_i(h_req), .h_we_i(h_we), .h_addr_i(h_addr), .h_wdata_i(h_wdata),
        .h_wstrb_i(h_wstrb), .h_gnt_o(h_gnt), .h_rvalid_o(h_rv),
        .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
        .d_wstrb_i(d_wstrb), .d_gnt_o(d_gnt), .d_rvalid_o(d_rv),
        .i_req_i(i_req), .i_addr_i(i_addr), .i_gnt_o(i_gnt), .i_rvalid_o(i_rv),
        .rdata_o(rdata), .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory array the DUT drives (environment, not the checker).
    logic [31:0] mem [0:(1<<AW)-1];
    initial for (int k = 0; k < (1<<AW); k++) mem[k] = 32'h0;
    always @(posedge clk) begin
        if (mem_en) begin
            for (int b = 0; b < 4; b++)
                if (mem_we[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            mem_rdata <= mem[mem_addr];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: who wins, what memory holds, which read returns next.
    logic [31:0] mm [0:(1<<AW)-1];
    initial for (int k = 0; k < (1<<AW); k++) mm[k] = 32'h0;
    int  m_hcount = 0;   // host grants since CPU last served or went idle
    bit  m_next_i = 0;   // CPU port owed the next contended slot is I
    int  m_pend   = 0;   // 0 none, 1 H, 2 D, 3 I
    logic [31:0] m_pdata;

    always @(negedge clk) begin
        int g, w;
        bit cpu, we;
        logic [31:0] a, wd;
        logic [3:0] st;
        if (!rst_n) begin
            chk("rst_gnt", {29'd0, h_gnt, d_gnt, i_gnt}, 32'd0);
            chk("rst_en", {31'd0, mem_en}, 32'd0);
            chk("rst_we", {28'd0, mem_we}, 32'd0);
            chk("rst_rvalid", {29'd0, h_rv, d_rv, i_rv}, 32'd0);
            m_hcount = 0; m_next_i = 0; m_pend = 0;
        end else begin
            chk("rvalid", {29'd0, h_rv, d_rv, i_rv},
                m_pend == 1 ? 32'd4 : m_pend == 2 ? 32'd2 : m_pend == 3 ? 32'd1 : 32'd0);
            if (m_pend != 0) chk("rdata", rdata, m_pdata);
            cpu = d_req || i_req;
            g = 0;
            if (h_req && (m_hcount < HMB || !cpu)) g = 1;
            else if (d_req && i_req)               g = m_next_i ? 3 : 2;
            else if (d_req)                        g = 2;
            else if (i_req)                        g = 3;
            chk("gnt", {29'd0, h_gnt, d_gnt, i_gnt},
                g == 1 ? 32'd4 : g == 2 ? 32'd2 : g == 3 ? 32'd1 : 32'd0);
            chk("mem_en", {31'd0, mem_en}, {31'd0, g != 0});
            m_pend = 0;
            if (g != 0) begin
                a  = g == 1 ? h_addr  : g == 2 ? d_addr  : i_addr;
                we = g == 1 ? h_we    : g == 2 ? d_we    : 1'b0;
                wd = g == 1 ? h_wdata : d_wdata;
                st = g == 1 ? h_wstrb : d_wstrb;
                w  = int'(a[AW+1:2]);
                chk("mem_addr", {22'd0, mem_addr}, w);
                chk("mem_we", {28'd0, mem_we}, we ? {28'd0, st} : 32'd0);
                if (we) begin
                    chk("mem_wdata", mem_wdata, wd);
                    for (int b = 0; b < 4; b++) if (st[b]) mm[w][8*b +: 8] = wd[8*b +: 8];
                end else begin
                    m_pend = g;
                    m_pdata = mm[w];
                end
            end
            if (g == 1 && m_hcount < 15) m_hcount++;
            if (g >= 2) begin m_hcount = 0; m_next_i = (g == 2); end
            if (!cpu) m_hcount = 0;
        end
    end

    task automatic step(); @(posedge clk); #1; endtask
    task automatic settle(); #2; endtask

    task automatic hcmd(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] st);
        h_req = 1; h_we = we; h_addr = a; h_wdata = wd; h_wstrb = st;
    endtask

    initial begin
        // Reset with everyone requesting: grants must stay low.
        step(); step();
        h_req = 1; d_req = 1; i_req = 1;
        settle();
        chk("lit_rst_gnt", {29'd0, h_gnt, d_gnt, i_gnt}, 32'd0);
        chk("lit_rst_en", {31'd0, mem_en}, 32'd0);
        h_req = 0; d_req = 0; i_req = 0;
        step();
        rst_n = 1;

        // Host write then read-back.
        hcmd(1, 32'h10, 32'hDEADBEEF, 4'hF);
        settle();
        chk("lit_h_gnt", {31'd0, h_gnt}, 32'd1);
        chk("lit_h_we", {28'd0, mem_we}, 32'hF);
        chk("lit_h_addr", {22'd0, mem_addr}, 32'd4);
        step();
        hcmd(0, 32'h10, 32'h0, 4'h0);
        step();
        h_req = 0;
        settle();
        chk("lit_h_rvalid", {31'd0, h_rv}, 32'd1);
        chk("lit_h_rdata", rdata, 32'hDEADBEEF);
        step();

        // Preload for D/I, then alternating contention.
        hcmd(1, 32'h20, 32'h0D0D0D0D, 4'hF); step();
        hcmd(1, 32'h40, 32'h11112222, 4'hF); step();
        h_req = 0;
        d_req = 1; d_we = 0; d_addr = 32'h20;
        i_req = 1; i_addr = 32'h40;
        for (int k = 0; k < 8; k++) begin
            settle();
            chk("lit_alt", {30'd0, d_gnt, i_gnt}, (k % 2 == 0) ? 32'd2 : 32'd1);
            step();
        end

        // Three-way contention: four host slots per CPU slot.
        hcmd(0, 32'h10, 32'h0, 4'h0);
        for (int k = 0; k < 20; k++) begin
            settle();
            chk("lit_burst", {29'd0, h_gnt, d_gnt, i_gnt},
                (k % 5 < 4) ? 32'd4 : (((k / 5) % 2 == 0) ? 32'd2 : 32'd1));
            step();
        end
        h_req = 0; d_req = 0; i_req = 0;
        step();

        // Partial-strobe merge, zero-strobe write, aliased D read.
        hcmd(1, 32'h80, 32'h11223344, 4'hF); step();
        hcmd(1, 32'h80, 32'h000000AA, 4'h1); step();
        hcmd(1, 32'h80, 32'hFFFFFFFF, 4'h0);
        settle();
        chk("lit_zstrb_en", {31'd0, mem_en}, 32'd1);
        chk("lit_zstrb_we", {28'd0, mem_we}, 32'd0);
        step();
        h_req = 0;
        d_req = 1; d_addr = 32'h80;
        settle();
        chk("lit_zstrb_norv", {29'd0, h_rv, d_rv, i_rv}, 32'd0);
        step();
        d_addr = 32'h0000_1083;   // aliases word 0x20
        settle();
        chk("lit_d_rv", {29'd0, h_rv, d_rv, i_rv}, 32'd2);
        chk("lit_merge", rdata, 32'h112233AA);
        chk("lit_alias_addr", {22'd0, mem_addr}, 32'h20);
        step();
        d_req = 0;
        settle();
        chk("lit_alias_rdata", rdata, 32'h112233AA);
        step();

        // Host alone never runs out of burst budget.
        hcmd(0, 32'h10, 32'h0, 4'h0);
        for (int k = 0; k < 20; k++) begin
            settle();
            chk("lit_h_only", {31'd0, h_gnt}, 32'd1);
            step();
        end
        h_req = 0;
        step();

        // Fetch read killed by reset before its return cycle.
        i_req = 1; i_addr = 32'h40;
        settle();
        chk("lit_i_gnt", {31'd0, i_gnt}, 32'd1);
        #5;
        rst_n = 0;
        i_req = 0;
        step();
        d_req = 1; d_addr = 32'h20; i_req = 1;
        settle();
        chk("lit_i_rv_killed", {31'd0, i_rv}, 32'd0);
        chk("lit_rst2_gnt", {29'd0, h_gnt, d_gnt, i_gnt}, 32'd0);
        step(); step();
        rst_n = 1;
        settle();
        chk("lit_post_rst_d", {30'd0, d_gnt, i_gnt}, 32'd2);
        step();
        settle();
        chk("lit_post_rst_i", {30'd0, d_gnt, i_gnt}, 32'd1);
        chk("lit_post_rst_drv", {29'd0, h_rv, d_rv, i_rv}, 32'd2);
        chk("lit_post_rst_dat", rdata, 32'h0D0D0D0D);
        step();
        d_req = 0; i_req = 0;
        step(); step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
